// File: rtl/joltage_pkg.sv
// Shared types and helpers for the multi-digit joltage selector.
//   bcd_digit_t    : one BCD digit (4 bits)
//   state_t        : controller states COLLECT / CONVERT / OUTPUT
//   BCD_MAX        : largest legal BCD digit
//   MAX_DIGITS     : widest bank the candidate helper can handle
//   remove_append  : drop nibble i from a packed bank, close the gap, append d as LSB
package joltage_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CONVERT = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  localparam int MAX_DIGITS = 32;
  localparam int BANK_MAX_W = 4 * MAX_DIGITS;

  typedef logic [BANK_MAX_W-1:0] bank_max_t;

  // Nibbles above i stay in place, nibbles below i move up one slot, d fills the LSB.
  // Callers zero-extend their bank into bank_max_t and truncate the result back.
  function automatic bank_max_t remove_append(input bank_max_t bank,
                                              input int unsigned i,
                                              input bcd_digit_t d);
    bank_max_t lo_mask;
    bank_max_t hi_mask;
    lo_mask = (bank_max_t'(1) << (4 * i)) - bank_max_t'(1);
    hi_mask = ~((bank_max_t'(1) << (4 * i + 4)) - bank_max_t'(1));
    return (bank & hi_mask) | ((bank & lo_mask) << 4) | bank_max_t'(d);
  endfunction

endpackage

// File: rtl/joltage_bcd2bin_seq.sv
// Iterative packed-BCD to binary converter, one digit per cycle, MSB nibble first.
// Ports:
//   clock, reset : clock, synchronous active-high reset
//   start_i      : load bcd_i and begin a DIGITS-cycle conversion
//   bcd_i        : packed BCD value, most significant digit in the top nibble
//   busy_o       : conversion in progress
//   done_o       : high during the final conversion cycle; result_o is final after this edge
//   result_o     : binary accumulator (holds the last result until the next start)
module joltage_bcd2bin_seq
  import joltage_pkg::*;
#(
  parameter int DIGITS = 12,
  parameter int BIN_W  = 40
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start_i,
  input  logic [4*DIGITS-1:0] bcd_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [BIN_W-1:0]    result_o
);

  localparam int CW = $clog2(DIGITS + 1);

  logic [4*DIGITS-1:0] shreg_q, shreg_d;
  logic [BIN_W-1:0]    acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  bcd_digit_t          top_nib;

  assign top_nib  = shreg_q[4*DIGITS-1 -: 4];
  assign done_o   = busy_q && (cnt_q == CW'(DIGITS - 1));
  assign busy_o   = busy_q;
  assign result_o = acc_q;

  always_comb begin
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start_i) begin
      shreg_d = bcd_i;
      acc_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      acc_d   = acc_q * BIN_W'(10) + BIN_W'(top_nib);
      shreg_d = shreg_q << 4;
      if (done_o) busy_d = 1'b0;
      else        cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // Shift register contents are only meaningful while busy.
  always_ff @(posedge clock) begin
    shreg_q <= shreg_d;
  end

endmodule

// File: rtl/multi_digit_joltager.sv
// Streaming K-digit max-joltage selector. Keeps the largest DIGITS-long ordered
// subsequence of each bank's BCD digits, converts it to binary, hands it off on a
// ready/valid port and keeps a running sum and count of handed-off banks.
// Optional build macro: JOLTAGER_SUM_SATURATE_EN -- joltage_sum clamps at its maximum
// instead of wrapping.
// Ports:
//   clock, reset : clock, synchronous active-high reset
//   in_valid / in_ready / in_digit / in_last : digit stream, in_last marks a bank's final digit
//   out_valid / out_ready / out_joltage      : completed bank value
//   joltage_sum  : sum of handed-off banks
//   line_count   : number of handed-off banks (wraps)
//   digit_err    : sticky flag, a digit above 9 was accepted (and treated as 0)
module multi_digit_joltager
  import joltage_pkg::*;
#(
  parameter int DIGITS = 12,
  parameter int BIN_W  = 40,
  parameter int SUM_W  = 56,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIN_W-1:0] out_joltage,
  output logic [SUM_W-1:0] joltage_sum,
  output logic [CNT_W-1:0] line_count,
  output logic             digit_err
);

  localparam int BANK_W = 4 * DIGITS;
  localparam int FILL_W = $clog2(DIGITS + 1);
  localparam int ADD_W  = ((SUM_W > BIN_W) ? SUM_W : BIN_W) + 1;

  function automatic logic [SUM_W-1:0] sum_add(input logic [SUM_W-1:0] a,
                                               input logic [BIN_W-1:0] b);
    logic [ADD_W-1:0] s;
    s = ADD_W'(a) + ADD_W'(b);
`ifdef JOLTAGER_SUM_SATURATE_EN
    if (s > ADD_W'({SUM_W{1'b1}})) return {SUM_W{1'b1}};
`endif
    return SUM_W'(s);
  endfunction

  state_t            state_q, state_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;

  logic              accept, handshake;
  bcd_digit_t        digit;
  logic [BANK_W-1:0] cand [DIGITS];
  logic [BANK_W-1:0] best;

  logic              conv_start, conv_busy, conv_done;
  logic [BIN_W-1:0]  conv_result;

  assign accept     = in_valid && in_ready;
  assign handshake  = out_valid && out_ready;
  assign digit      = (in_digit > BCD_MAX) ? 4'd0 : in_digit;
  assign conv_start = accept && in_last;

  // One candidate per removable nibble; the bank itself wins ties.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_cand
    assign cand[gi] = BANK_W'(remove_append(bank_max_t'(bank_q), gi, digit));
  end

  always_comb begin
    best = bank_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (cand[i] > best) best = cand[i];
    end
  end

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (accept && in_last) state_d = CONVERT;
      CONVERT: if (conv_done)         state_d = OUTPUT;
      OUTPUT:  if (out_ready)         state_d = COLLECT;
      default:                        state_d = COLLECT;
    endcase
  end

  // FSM: outputs. The busy term keeps a new bank out while a conversion is still running.
  always_comb begin
    in_ready  = (state_q == COLLECT) && !conv_busy;
    out_valid = (state_q == OUTPUT);
  end

  always_comb begin
    bank_d  = bank_q;
    fill_d  = fill_q;
    sum_d   = sum_q;
    count_d = count_q;
    err_d   = err_q;
    if (accept) begin
      if (in_digit > BCD_MAX) err_d = 1'b1;
      if (fill_q < FILL_W'(DIGITS)) begin
        // Truncating cast drops the (empty) top nibble; also covers DIGITS=1.
        bank_d = BANK_W'({bank_q, digit});
        fill_d = fill_q + 1'b1;
      end else begin
        bank_d = best;
      end
    end
    if (handshake) begin
      sum_d   = sum_add(sum_q, conv_result);
      count_d = count_q + 1'b1;
      bank_d  = '0;
      fill_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bank_q  <= '0;
      fill_q  <= '0;
      sum_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      bank_q  <= bank_d;
      fill_q  <= fill_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Converter is loaded with the bank as it will look after the final digit lands.
  joltage_bcd2bin_seq #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) u_bcd2bin (
    .clock    (clock),
    .reset    (reset),
    .start_i  (conv_start),
    .bcd_i    (bank_d),
    .busy_o   (conv_busy),
    .done_o   (conv_done),
    .result_o (conv_result)
  );

  assign out_joltage = conv_result;
  assign joltage_sum = sum_q;
  assign line_count  = count_q;
  assign digit_err   = err_q;

endmodule
